// File: rtl/snn_pkg.sv
// Shared types and default widths for the spiking-network datapath stages.
package snn_pkg;

   localparam int SUM_WIDTH     = 19;
   localparam int V_WIDTH_DEF   = 24;
   localparam int CNT_WIDTH_DEF = 16;

   typedef enum logic {
      INTEGRATE = 1'b0,
      REFRACT   = 1'b1
   } lif_state_t;

endpackage

// File: rtl/lif_neuron_if.sv
// Timestep-sum input and spike/readout output bundle of one LIF neuron.
interface lif_neuron_if #(
   parameter int SUM_WIDTH = snn_pkg::SUM_WIDTH,
   parameter int V_WIDTH   = snn_pkg::V_WIDTH_DEF,
   parameter int CNT_WIDTH = snn_pkg::CNT_WIDTH_DEF
);
   logic                 sumValid;
   logic [SUM_WIDTH-1:0] sumIn;
   logic [V_WIDTH-1:0]   threshold;
   logic                 countClr;
   logic                 spikeOut;
   logic [V_WIDTH-1:0]   vMem;
   logic                 refractory;
   logic [CNT_WIDTH-1:0] spikeCount;

   modport master (
      output sumValid, sumIn, threshold, countClr,
      input  spikeOut, vMem, refractory, spikeCount
   );

   modport slave (
      input  sumValid, sumIn, threshold, countClr,
      output spikeOut, vMem, refractory, spikeCount
   );
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear plus increment yields 1.
module sat_counter #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc_i,
   input  logic             clr_i,
   output logic [WIDTH-1:0] count_o
);
   logic [WIDTH-1:0] count_q, count_d;

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
      count_d = count_q;
      if (clr_i)
         count_d = inc_i ? WIDTH'(1) : '0;
      else if (inc_i && (count_q != '1))
         count_d = count_q + WIDTH'(1);
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) count_q <= '0;
      else     count_q <= count_d;
   end

   assign count_o = count_q;
endmodule

// File: rtl/lif_neuron.sv
// Leaky integrate-and-fire neuron: shift leak, saturating add, threshold fire, refractory hold.
module lif_neuron #(
   parameter int SUM_WIDTH     = snn_pkg::SUM_WIDTH,
   parameter int V_WIDTH       = snn_pkg::V_WIDTH_DEF,
   parameter int LEAK_SHIFT    = 4,
   parameter int REFRACT_STEPS = 2,
   parameter int CNT_WIDTH     = snn_pkg::CNT_WIDTH_DEF
) (
   input logic         clk,
   input logic         rst,
   lif_neuron_if.slave bus
);
   import snn_pkg::*;

   localparam int RW = (REFRACT_STEPS > 0) ? $clog2(REFRACT_STEPS + 1) : 1;

   lif_state_t         state_q, state_d;
   logic [V_WIDTH-1:0] vmem_q, vmem_d;
   logic               spike_q, spike_d;
   logic [RW-1:0]      rcnt_q, rcnt_d;

   logic [V_WIDTH-1:0] v_leak;
   logic [V_WIDTH:0]   v_sum_wide;
   logic [V_WIDTH-1:0] v_sum;
   logic               fire;

   // Carry out of the widened add means overflow; clamp to full scale.
   assign v_leak     = vmem_q - (vmem_q >> LEAK_SHIFT);
   assign v_sum_wide = {1'b0, v_leak} + (V_WIDTH+1)'(bus.sumIn);
   assign v_sum      = v_sum_wide[V_WIDTH] ? '1 : v_sum_wide[V_WIDTH-1:0];
   assign fire       = bus.sumValid && (state_q == INTEGRATE) && (v_sum >= bus.threshold);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= INTEGRATE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         INTEGRATE: if (fire && (REFRACT_STEPS > 0)) state_d = REFRACT;
         REFRACT:   if (bus.sumValid && (rcnt_q == RW'(1))) state_d = INTEGRATE;
      endcase
   end

   always_comb begin
      vmem_d  = vmem_q;
      spike_d = 1'b0;
      rcnt_d  = rcnt_q;
      if (bus.sumValid) begin
         unique case (state_q)
            INTEGRATE: begin
               if (fire) begin
                  spike_d = 1'b1;
                  vmem_d  = '0;
                  rcnt_d  = RW'(REFRACT_STEPS);
               end else begin
                  vmem_d  = v_sum;
               end
            end
            REFRACT: begin
               vmem_d = '0;
               rcnt_d = rcnt_q - RW'(1);
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vmem_q  <= '0;
         spike_q <= 1'b0;
         rcnt_q  <= '0;
      end else begin
         vmem_q  <= vmem_d;
         spike_q <= spike_d;
         rcnt_q  <= rcnt_d;
      end
   end

   sat_counter #(.WIDTH(CNT_WIDTH)) u_spike_cnt (
      .clk     (clk),
      .rst     (rst),
      .inc_i   (fire),
      .clr_i   (bus.countClr),
      .count_o (bus.spikeCount)
   );

   assign bus.vMem       = vmem_q;
   assign bus.spikeOut   = spike_q;
   assign bus.refractory = (state_q == REFRACT);
endmodule

// File: tb/tb_lif_neuron.sv
// Three LIF neuron configurations checked against a timestep-level behavioural model.
module tb_lif_neuron;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // Instance configs: 0 = defaults, 1 = narrow potential, 2 = no refractory + 4-bit count.
   int vw [3] = '{24, 20, 24};
   int ls [3] = '{4, 4, 4};
   int rs [3] = '{2, 2, 0};
   int cw [3] = '{16, 16, 4};

   logic        valid [3];
   logic [63:0] sum   [3];
   logic [63:0] thr   [3];
   logic        clr   [3];

   logic        obs_s [3];
   logic        obs_r [3];
   logic [63:0] obs_v [3];
   logic [63:0] obs_c [3];

   lif_neuron_if                                  if_a ();
   lif_neuron_if #(.V_WIDTH(20))                  if_b ();
   lif_neuron_if #(.CNT_WIDTH(4))                 if_c ();

   lif_neuron u_a (.clk(clk), .rst(rst), .bus(if_a.slave));
   lif_neuron #(.V_WIDTH(20)) u_b (.clk(clk), .rst(rst), .bus(if_b.slave));
   lif_neuron #(.REFRACT_STEPS(0), .CNT_WIDTH(4)) u_c (.clk(clk), .rst(rst), .bus(if_c.slave));

   assign if_a.sumValid = valid[0]; assign if_a.sumIn = sum[0][18:0];
   assign if_a.threshold = thr[0][23:0]; assign if_a.countClr = clr[0];
   assign if_b.sumValid = valid[1]; assign if_b.sumIn = sum[1][18:0];
   assign if_b.threshold = thr[1][19:0]; assign if_b.countClr = clr[1];
   assign if_c.sumValid = valid[2]; assign if_c.sumIn = sum[2][18:0];
   assign if_c.threshold = thr[2][23:0]; assign if_c.countClr = clr[2];

   assign obs_s[0] = if_a.spikeOut; assign obs_r[0] = if_a.refractory;
   assign obs_v[0] = 64'(if_a.vMem); assign obs_c[0] = 64'(if_a.spikeCount);
   assign obs_s[1] = if_b.spikeOut; assign obs_r[1] = if_b.refractory;
   assign obs_v[1] = 64'(if_b.vMem); assign obs_c[1] = 64'(if_b.spikeCount);
   assign obs_s[2] = if_c.spikeOut; assign obs_r[2] = if_c.refractory;
   assign obs_v[2] = 64'(if_c.vMem); assign obs_c[2] = 64'(if_c.spikeCount);

   typedef struct {
      longint v;
      int     hold;
      longint cnt;
      bit     spk;
   } mdl_t;

   mdl_t m [3];
   int   n_vec = 0;
   int   n_err = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // One timestep of the neuron as described behaviourally.
   function automatic mdl_t model_step(input mdl_t s, input int i);
      mdl_t   n;
      longint vs;
      longint vmax;
      longint cmax;
      bit     fired;
      n     = s;
      n.spk = 1'b0;
      fired = 1'b0;
      vmax  = (longint'(1) << vw[i]) - 1;
      cmax  = (longint'(1) << cw[i]) - 1;
      if (valid[i]) begin
         if (s.hold > 0) begin
            n.hold = s.hold - 1;
            n.v    = 0;
         end else begin
            vs = s.v - (s.v >> ls[i]) + longint'(sum[i]);
            if (vs > vmax) vs = vmax;
            if (vs >= longint'(thr[i])) begin
               fired  = 1'b1;
               n.spk  = 1'b1;
               n.v    = 0;
               n.hold = rs[i];
            end else begin
               n.v = vs;
            end
         end
      end
      if (clr[i])                  n.cnt = fired ? 1 : 0;
      else if (fired && s.cnt < cmax) n.cnt = s.cnt + 1;
      return n;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 3; i++) m[i] = '{v: 0, hold: 0, cnt: 0, spk: 1'b0};
   endtask

   task automatic idle_inputs();
      for (int i = 0; i < 3; i++) begin
         valid[i] = 1'b0;
         sum[i]   = '0;
         clr[i]   = 1'b0;
      end
   endtask

   // Advance one clock, step the model, then compare every output of every instance.
   task automatic tick();
      @(posedge clk);
      for (int i = 0; i < 3; i++) m[i] = model_step(m[i], i);
      #1;
      for (int i = 0; i < 3; i++) begin
         check($sformatf("u%0d.vMem", i),       obs_v[i], 64'(m[i].v));
         check($sformatf("u%0d.spikeOut", i),   64'(obs_s[i]), 64'(m[i].spk));
         check($sformatf("u%0d.refractory", i), 64'(obs_r[i]), 64'(m[i].hold > 0));
         check($sformatf("u%0d.spikeCount", i), obs_c[i], 64'(m[i].cnt));
      end
      idle_inputs();
   endtask

   task automatic apply(input int i, input longint s, input bit c);
      valid[i] = 1'b1;
      sum[i]   = 64'(s);
      clr[i]   = c;
      tick();
   endtask

   initial begin
      idle_inputs();
      thr[0] = 64'd1000; thr[1] = 64'hFFFFF; thr[2] = 64'd0;
      model_reset();
      #23;
      for (int i = 0; i < 3; i++) begin
         check($sformatf("rst0.u%0d.vMem", i),  obs_v[i], 64'd0);
         check($sformatf("rst0.u%0d.spike", i), 64'(obs_s[i]), 64'd0);
         check($sformatf("rst0.u%0d.cnt", i),   obs_c[i], 64'd0);
      end
      rst = 1'b0;

      // Leak and integrate with idle gaps.
      apply(0, 100, 1'b0); check("integ.v1", obs_v[0], 64'd100);
      tick();              check("integ.idle1", obs_v[0], 64'd100);
      apply(0, 100, 1'b0); check("integ.v2", obs_v[0], 64'd194);
      tick(); tick();      check("integ.idle2", obs_v[0], 64'd194);
      apply(0, 100, 1'b0); check("integ.v3", obs_v[0], 64'd282);
      check("integ.nospk", obs_c[0], 64'd0);

      // Asynchronous reset between clock edges.
      #2 rst = 1'b1;
      #1;
      check("arst.vMem",  obs_v[0], 64'd0);
      check("arst.spike", 64'(obs_s[0]), 64'd0);
      check("arst.refr",  64'(obs_r[0]), 64'd0);
      check("arst.cnt",   obs_c[0], 64'd0);
      model_reset();
      #1 rst = 1'b0;

      // Fire on the third sample.
      thr[0] = 64'd250;
      apply(0, 100, 1'b0);
      apply(0, 100, 1'b0);
      apply(0, 100, 1'b0);
      check("fire.spike", 64'(obs_s[0]), 64'd1);
      check("fire.vMem",  obs_v[0], 64'd0);
      check("fire.refr",  64'(obs_r[0]), 64'd1);
      check("fire.cnt",   obs_c[0], 64'd1);

      // Refractory window swallows two samples.
      thr[0] = 64'd1000;
      apply(0, 500, 1'b0);
      check("refr1.vMem", obs_v[0], 64'd0);
      check("refr1.spike", 64'(obs_s[0]), 64'd0);
      check("refr1.refr", 64'(obs_r[0]), 64'd1);
      apply(0, 500, 1'b0);
      check("refr2.vMem", obs_v[0], 64'd0);
      check("refr2.refr", 64'(obs_r[0]), 64'd0);
      apply(0, 500, 1'b0);
      check("refr3.vMem", obs_v[0], 64'd500);

      // Saturating add on the 20-bit instance.
      apply(1, 64'h7FFFF, 1'b0); check("sat.v1", obs_v[1], 64'h7FFFF);
      apply(1, 64'h7FFFF, 1'b0); check("sat.v2", obs_v[1], 64'hF7FFF);
      apply(1, 64'h7FFFF, 1'b0);
      check("sat.spike", 64'(obs_s[1]), 64'd1);
      check("sat.vMem",  obs_v[1], 64'd0);

      // Back-to-back firing and count saturation with no refractory period.
      for (int k = 0; k < 20; k++) begin
         apply(2, 64'(k), 1'b0);
         check($sformatf("b2b.spike%0d", k), 64'(obs_s[2]), 64'd1);
      end
      check("cnt.sat", obs_c[2], 64'd15);
      apply(2, 5, 1'b1);
      check("cnt.clr_spike", obs_c[2], 64'd1);
      clr[2] = 1'b1;
      tick();
      check("cnt.clr_only", obs_c[2], 64'd0);

      // Randomised traffic on all three instances at once.
      for (int cyc = 0; cyc < 600; cyc++) begin
         if (cyc % 64 == 0) begin
            for (int i = 0; i < 3; i++)
               thr[i] = 64'($urandom_range(0, (1 << vw[i]) - 1) >> $urandom_range(0, vw[i]));
         end
         for (int i = 0; i < 3; i++) begin
            valid[i] = ($urandom_range(0, 9) < 7);
            sum[i]   = 64'($urandom_range(0, (1 << 19) - 1) >> $urandom_range(0, 14));
            clr[i]   = ($urandom_range(0, 31) == 0);
         end
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not reach the summary");
      $fatal(1);
   end

endmodule
